// File: rtl/fp32_pkg.sv
// Shared constants, operand classification and unpack helper for the
// single-precision multiplier pipeline.
package fp32_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned PROD_W = 2 * SIG_W;
  localparam int unsigned EEXP_W = 10;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0001;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_cls_e;

  typedef struct packed {
    logic             sign;
    fp_cls_e          cls;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } fp_unp_t;

  // Exponent-0 encodings (zero and subnormal) collapse to signed zero.
  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.sig  = {1'b1, x[22:0]};
    if (x[30:23] == '0)
      u.cls = CLS_ZERO;
    else if (x[30:23] == '1)
      u.cls = (x[22:0] == '0) ? CLS_INF : CLS_NAN;
    else
      u.cls = CLS_NORM;
    return u;
  endfunction

endpackage

// File: rtl/fp32_mul_round.sv
// Normalize a 48-bit significand product and round to nearest, ties to even.
module fp32_mul_round
  import fp32_pkg::*;
(
  input  logic [PROD_W-1:0]        prod_i,
  input  logic signed [EEXP_W-1:0] exp_i,
  output logic [MAN_W-1:0]         man_o,
  output logic signed [EEXP_W-1:0] exp_o,
  output logic                     carry_o
);

  logic [MAN_W-1:0]         mant;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [SIG_W-1:0]         sum;
  logic signed [EEXP_W-1:0] exp_n;

  always_comb begin
    if (prod_i[PROD_W-1]) begin
      mant   = prod_i[46:24];
      guard  = prod_i[23];
      sticky = |prod_i[22:0];
      exp_n  = exp_i + 10'sd1;
    end else begin
      mant   = prod_i[45:23];
      guard  = prod_i[22];
      sticky = |prod_i[21:0];
      exp_n  = exp_i;
    end
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + SIG_W'(round_up);
    // A carry out means the rounded significand is exactly 2.0: fraction is zero.
    carry_o  = sum[SIG_W-1];
    man_o    = sum[MAN_W-1:0];
    exp_o    = carry_o ? exp_n + 10'sd1 : exp_n;
  end

endmodule

// File: rtl/fp32_mul_pipe.sv
// Three-stage IEEE-754 single-precision multiplier with a single global
// advance enable; output register doubles as the result holding stage.
module fp32_mul_pipe
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  localparam logic signed [EEXP_W-1:0] EXP_MAX_S = EEXP_W'(EXP_MAX);

  logic adv;

  fp_unp_t                  ua, ub;
  fp_cls_e                  cls1_d;
  logic signed [EEXP_W-1:0] exp1_d;
  logic [PROD_W-1:0]        prod1_d;

  logic                     v1_q, sign1_q;
  fp_cls_e                  cls1_q;
  logic signed [EEXP_W-1:0] exp1_q;
  logic [PROD_W-1:0]        prod1_q;

  logic [MAN_W-1:0]         rnd_man;
  logic signed [EEXP_W-1:0] rnd_exp;
  logic                     rnd_carry;

  logic                     v2_q, sign2_q;
  fp_cls_e                  cls2_q;
  logic signed [EEXP_W-1:0] exp2_q;
  logic [MAN_W-1:0]         man2_d, man2_q;

  logic [31:0] result_d, result_q;
  logic        ovf_d, ovf_q, unf_d, unf_q, out_valid_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // S1: classify, exponent sum, significand product
  always_comb begin
    ua      = fp_unpack(a);
    ub      = fp_unpack(b);
    exp1_d  = EEXP_W'(ua.exp) + EEXP_W'(ub.exp) - EEXP_W'(EXP_BIAS);
    prod1_d = PROD_W'(ua.sig) * PROD_W'(ub.sig);
    if (ua.cls == CLS_NAN || ub.cls == CLS_NAN)
      cls1_d = CLS_NAN;
    else if ((ua.cls == CLS_INF && ub.cls == CLS_ZERO) ||
             (ub.cls == CLS_INF && ua.cls == CLS_ZERO))
      cls1_d = CLS_NAN;
    else if (ua.cls == CLS_INF || ub.cls == CLS_INF)
      cls1_d = CLS_INF;
    else if (ua.cls == CLS_ZERO || ub.cls == CLS_ZERO)
      cls1_d = CLS_ZERO;
    else
      cls1_d = CLS_NORM;
  end

  // S2: normalize and round
  fp32_mul_round u_round (
    .prod_i  (prod1_q),
    .exp_i   (exp1_q),
    .man_o   (rnd_man),
    .exp_o   (rnd_exp),
    .carry_o (rnd_carry)
  );

  assign man2_d = rnd_carry ? '0 : rnd_man;

  // S3: pack with saturation / flush
  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    unique case (cls2_q)
      CLS_NAN:  result_d = QNAN;
      CLS_INF:  result_d = {sign2_q, 8'hFF, 23'd0};
      CLS_ZERO: result_d = {sign2_q, 31'd0};
      default: begin
        if (exp2_q >= EXP_MAX_S) begin
          result_d = {sign2_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (exp2_q <= 10'sd0) begin
          result_d = {sign2_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign2_q, exp2_q[EXP_W-1:0], man2_q};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q <= ua.sign ^ ub.sign;
      cls1_q  <= cls1_d;
      exp1_q  <= exp1_d;
      prod1_q <= prod1_d;
      sign2_q <= sign1_q;
      cls2_q  <= cls1_q;
      exp2_q  <= rnd_exp;
      man2_q  <= man2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// Bench for fp32_mul_pipe: directed vector table, latency/backpressure/reset
// sequences and a randomized stream against a behavioural reference model.
module tb_fp32_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic        overflow, underflow;

  always #5 clk = ~clk;

  fp32_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    string       name;
  } vec_t;

  typedef struct {
    logic [33:0] exp;
    string       name;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  // Reference: exact integer product, rounded by comparing the discarded
  // remainder against half an ulp. Returns {result, overflow, underflow}.
  function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, nx, ny, ix, iy, zx, zy;
    longint unsigned mx, my, p, q, rem, half;
    int e, sh;
    s  = x[31] ^ y[31];
    zx = (x[30:23] == 8'h00);
    zy = (y[30:23] == 8'h00);
    ix = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    iy = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (nx || ny || (ix && zy) || (iy && zx)) return {32'h7FC00001, 2'b00};
    if (ix || iy) return {s, 8'hFF, 23'd0, 2'b00};
    if (zx || zy) return {s, 31'd0, 2'b00};
    mx   = 64'(x[22:0]) + (64'd1 << 23);
    my   = 64'(y[22:0]) + (64'd1 << 23);
    p    = mx * my;
    e    = int'(x[30:23]) + int'(y[30:23]) - 127;
    sh   = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 2'b10};
    if (e <= 0)   return {s, 31'd0, 2'b01};
    return {s, 8'(e), 23'(q), 2'b00};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int unsigned k;
    r = $urandom;
    k = $urandom_range(0, 7);
    case (k)
      0: ;
      1: begin
        r[30:23] = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        if ($urandom_range(0, 1) != 0) r[22:0] = 23'd0;
      end
      2: r[30:23] = 8'($urandom_range(1, 20));
      3: r[30:23] = 8'($urandom_range(235, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive, check any valid output against the scoreboard
  // head, record acceptance, then advance to just after the rising edge.
  task automatic cycle(input logic iv, input logic [31:0] xa, input logic [31:0] xb,
                       input logic ordy, input logic [33:0] ex, input string nm,
                       output logic acc);
    in_valid  = iv;
    a         = xa;
    b         = xb;
    out_ready = ordy;
    #1;
    if (out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", {result, overflow, underflow});
      end else begin
        chk(sbq[0].name, {result, overflow, underflow}, sbq[0].exp);
        if (out_ready) void'(sbq.pop_front());
      end
    end
    acc = iv && in_ready;
    if (acc) sbq.push_back('{ex, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int   n;
    logic acc;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      cycle(1'b0, '0, '0, 1'b1, '0, "idle", acc);
      n++;
    end
    chk({nm, "_drained"}, sbq.size(), 0);
  endtask

  initial begin : main
    vec_t        vt[$];
    logic        acc;
    logic [31:0] bpa[6], bpb[6];
    logic [31:0] ra, rb;
    int          n, idx, seen;

    vt = '{
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, "one_x_one"},
      '{32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 1'b0, "two_x_three"},
      '{32'hC0000000, 32'h40400000, 32'hC0C00000, 1'b0, 1'b0, "neg_two_x_three"},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0, "round_near"},
      '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0, 1'b0, "tie_odd_up"},
      '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0, 1'b0, "tie_even_stay"},
      '{32'h7F800000, 32'h00000000, 32'h7FC00001, 1'b0, 1'b0, "inf_x_zero"},
      '{32'h80000000, 32'hFF800000, 32'h7FC00001, 1'b0, 1'b0, "zero_x_inf"},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00001, 1'b0, 1'b0, "nan_a"},
      '{32'hBF800000, 32'hFFC12345, 32'h7FC00001, 1'b0, 1'b0, "nan_b"},
      '{32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, "ninf_x_one"},
      '{32'hFF800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, "inf_x_inf"},
      '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, "subnormal_zero"},
      '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, "neg_zero"},
      '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, "overflow_pos"},
      '{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 1'b1, 1'b0, "overflow_neg"},
      '{32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1, "underflow_pos"},
      '{32'h80800000, 32'h00800000, 32'h80000000, 1'b0, 1'b1, "underflow_neg"}
    };

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, result, overflow, underflow}, '0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Latency: count rising edges from acceptance to out_valid.
    cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, {32'h3F800000, 2'b00}, "latency_value", acc);
    n = 1;
    while (!out_valid && n < 10) begin
      cycle(1'b0, '0, '0, 1'b1, '0, "idle", acc);
      n++;
    end
    chk("latency", n, 3);
    drain("latency");

    foreach (vt[i])
      cycle(1'b1, vt[i].a, vt[i].b, 1'b1, {vt[i].res, vt[i].ovf, vt[i].unf}, vt[i].name, acc);
    drain("table");

    // Backpressure: hold out_ready low for 5 cycles while streaming 6 ops.
    for (int i = 0; i < 6; i++) begin
      bpa[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
      bpb[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
    end
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 3) chk("bp_in_ready_low", in_ready, 0);
      cycle(idx < 6, bpa[idx % 6], bpb[idx % 6], 1'b0, ref_mul(bpa[idx % 6], bpb[idx % 6]),
            $sformatf("bp_op%0d", idx), acc);
      if (acc) idx++;
    end
    chk("bp_accepted_during_stall", idx, 3);
    n = 0;
    while (idx < 6 && n < 30) begin
      cycle(1'b1, bpa[idx % 6], bpb[idx % 6], 1'b1, ref_mul(bpa[idx % 6], bpb[idx % 6]),
            $sformatf("bp_op%0d", idx), acc);
      if (acc) idx++;
      n++;
    end
    chk("bp_all_accepted", idx, 6);
    drain("bp");
    repeat (4) cycle(1'b0, '0, '0, 1'b1, '0, "idle", acc);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      ra = rand_op();
      rb = rand_op();
      cycle(1'b1, ra, rb, 1'b1, ref_mul(ra, rb), "pre_reset", acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_out_valid", out_valid, 0);
    chk("reset_mid_result", {result, overflow, underflow}, '0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("reset_mid_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, '0, 1'b1, '0, "idle", acc);
      if (out_valid) seen++;
    end
    chk("reset_no_stale", seen, 0);

    // Randomized stream with random gaps and backpressure.
    for (int i = 0; i < 3000; i++) begin
      ra = rand_op();
      rb = rand_op();
      cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 9) < 7,
            ref_mul(ra, rb), $sformatf("rand_%h_%h", ra, rb), acc);
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_mul_pipe.md
FP32_MUL_PIPE -- requirements
Module: fp32_mul_pipe

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid  input  1  operand pair a/b valid this cycle.
REQ-004 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-005 SHALL have port a  input  32  IEEE-754 single operand (typically the reciprocal of a divisor).
REQ-006 SHALL have port b  input  32  IEEE-754 single operand.
REQ-007 SHALL have port out_valid  output  1  result valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts result.
REQ-009 SHALL have port result  output  32  product a*b.
REQ-010 SHALL have port overflow  output  1  qualified by out_valid; result saturated to infinity.
REQ-011 SHALL have port underflow  output  1  qualified by out_valid; result flushed to zero.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 unpack/classify/exponent sum/24x24 mantissa product; S2 normalize/round; S3 pack/flags (output register).
REQ-013 SHALL use a global advance enable adv = !out_valid | out_ready; in_ready = adv; all stages hold when adv=0.
REQ-014 SHALL transfer input on in_valid & in_ready; output on out_valid & out_ready; latency exactly 3 cycles with out_ready held high.
REQ-015 SHALL sustain one result per cycle with no stall; results leave in acceptance order; bubbles are not collapsed.
REQ-016 SHALL hold result/flags stable while out_valid=1 and out_ready=0.
REQ-017 SHALL treat exponent-0 inputs (zero and subnormal) as signed zero.
REQ-018 SHALL set sign = a[31]^b[31] for all non-NaN results.
REQ-019 SHALL output 32'h7FC00001 for: either input NaN; inf*zero in either order; flags 0.
REQ-020 SHALL output signed infinity for inf*finite-nonzero or inf*inf; flags 0.
REQ-021 SHALL output signed zero for zero*finite; flags 0.
REQ-022 SHALL compute normal case: E = ea+eb-127 (10-bit signed), P = ma*mb (48 bit, implicit 1s); if P[47] set, shift right 1 and E+1.
REQ-023 SHALL round to nearest, ties to even, using guard bit and OR of all lower bits as sticky; mantissa carry-out on rounding increments E.
REQ-024 SHALL, if final E >= 255, output signed infinity and overflow=1.
REQ-025 SHALL, if final E <= 0, output signed zero and underflow=1 (no subnormal outputs).

Reset
REQ-026 SHALL, on rst_n low, clear all stage valid bits immediately; out_valid=0, result=0, overflow=0, underflow=0.
REQ-027 SHALL drop any in-flight operations on reset mid-operation; none emitted after release.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset release.
REQ-029 SHALL not reset datapath registers other than result and flags.

Structure
REQ-030 SHALL import fp32_pkg containing EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00001, field widths and the unpacked-operand class type (zero/normal/inf/nan).
REQ-031 SHALL place S2 normalize+RNE in sub-module fp32_mul_round (combinational; 48-bit product and 10-bit exponent in; 23-bit mantissa, final exponent, carry out).
REQ-032 SHALL contain no other sub-modules; the 24x24 multiply is inferred.

Verification
REQ-033 SHALL cover 3F800000*3F800000 -> 3F800000 exactly 3 cycles after accept; 40000000*40400000 -> 40C00000.
REQ-034 SHALL cover rounding: 3F800001*3F800001 -> 3F800002; ties-to-even case with guard=1, sticky=0 rounds to even LSB.
REQ-035 SHALL cover specials: 7F800000*00000000 -> 7FC00001; FF800000*3F800000 -> FF800000; 00000001*3F800000 -> 00000000 (subnormal as zero).
REQ-036 SHALL cover limits: 7F7FFFFF*40000000 -> 7F800000, overflow=1; 00800000*00800000 -> 00000000, underflow=1.
REQ-037 SHALL cover backpressure: stream 6 ops, out_ready=0 for 5 cycles -> in_ready=0, result held stable, then all 6 emitted in order without loss or duplicate.
REQ-038 SHALL cover reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 at once, no stale result after release.
